instruction_fetch_unit: RTL and testbench
=========================================

Name: instruction_fetch_unit

Overview:
- Fetch-side master for the 12-bit-address, 16-bit-word instruction memory.
- Owns the program counter and drives the memory address and read-enable.
- Absorbs the memory's 1-cycle registered read latency and buffers fetched words in a small FIFO.
- Presents instructions to decode over a valid/ready handshake; supports branch redirect (flush) and halt.

Parameters:
- RESET_PC, 12'h000, PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries (power of 2, min 2).

Ports:
- i_clk  in  1  clock, all state on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- o_imem_addr  out  12  read address to instruction memory; equals the PC register.
- o_imem_en  out  1  read enable; memory stop input = ~o_imem_en.
- i_imem_data  in  16  memory read data; word for address issued at edge N is valid during cycle N+1 and holds while en=0.
- i_redirect  in  1  branch/jump redirect strobe.
- i_redirect_pc  in  12  redirect target.
- i_halt  in  1  stop issuing new fetches (level).
- o_inst_valid  out  1  FIFO head valid.
- o_inst  out  16  FIFO head instruction.
- o_inst_pc  out  12  PC of FIFO head.
- i_inst_ready  in  1  decode accepts head when valid&ready.

Behaviour:
Reset state:
- pc=RESET_PC; FIFO empty (count=0); pending=0.
- o_imem_en=0, o_inst_valid=0, o_inst=0, o_inst_pc=0.

Signal definitions:
- pop = o_inst_valid & i_inst_ready & ~i_redirect.
- issue (combinational, = o_imem_en) = ~i_reset & ~i_halt & ~i_redirect & (count + pending - pop < FIFO_DEPTH). Guarantees no FIFO overflow.

On issue:
- pending<=1, pend_pc<=pc, pc<=pc+1 (mod 4096; 4095 wraps to 0).

Pending capture:
- If pending=1 and no redirect: i_imem_data and pend_pc are written to the FIFO tail at the cycle's edge.
- pending<=issue.

Simultaneous push and pop:
- Both take effect; count unchanged.
- Order preserved; the FIFO is a circular buffer with wrapping read/write pointers.

Output timing:
- o_inst, o_inst_pc, o_inst_valid come from the FIFO head (valid = count>0).

Latency:
- Issue in cycle 0, word in FIFO at end of cycle 1, o_inst_valid in cycle 2.
- Sustained 1 instr/cycle with i_inst_ready held high.

Redirect (i_redirect=1 in cycle R):
- FIFO flushed (count<=0); the pending word is discarded; a head handshake in R is not counted.
- pc<=i_redirect_pc; no issue in R.
- First issue of the target is in R+1; valid in R+3.
- Redirect overrides halt for the PC update; issuing stays blocked while halted.

Halt:
- New issues are blocked.
- An in-flight word is still captured.
- The FIFO continues to drain to decode.
- Deasserting halt resumes issuing at the current pc.

Backpressure (i_inst_ready=0):
- FIFO fills to FIFO_DEPTH, then issue stops.
- o_inst and o_inst_pc are held stable while valid & ~ready.

Reset mid-operation:
- Returns to the reset state on the next edge regardless of pending, halt or redirect.

Test Plan:
- Reset, then release with ready=1, memory preloaded mem[k]=16'h1000+k -> o_imem_addr 0,1,2,... one per cycle; first valid 2 cycles after release; o_inst=16'h1000, o_inst_pc=0, then 16'h1001/1, consecutive with no bubbles.
- Hold ready=0 from cycle 0 -> exactly FIFO_DEPTH(2) entries (pc 0,1) buffered, o_imem_en=0 thereafter, outputs stable; assert ready -> entries 0,1 then 2,3,... delivered in order with no duplicates or loss.
- Redirect to 12'h080 while stream is mid-flight (FIFO holding pc 5, pending pc 6) -> neither pc 5 nor 6 is delivered after R; next delivered o_inst_pc=0x080 with mem[0x080], valid at R+3.
- Start RESET_PC=12'hFFE, ready=1 -> delivered PCs FFE, FFF, 000, 001 with matching data.
- Assert halt for 4 cycles mid-stream -> the in-flight word is still delivered, o_imem_en=0 during halt; after release fetching resumes at the next sequential PC, with no gaps or duplicates.
- Assert i_reset while FIFO full and pending=1 -> next cycle o_inst_valid=0, o_imem_en=0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues reads to the 12-bit/16-bit
// instruction memory, absorbs its one-cycle read latency and buffers the
// returned words in a small circular FIFO that feeds decode over valid/ready.
module instruction_fetch_unit #(
   parameter logic [11:0] RESET_PC   = 12'h000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   output logic [11:0] o_imem_addr,
   output logic        o_imem_en,
   input  logic [15:0] i_imem_data,
   input  logic        i_redirect,
   input  logic [11:0] i_redirect_pc,
   input  logic        i_halt,
   output logic        o_inst_valid,
   output logic [15:0] o_inst,
   output logic [11:0] o_inst_pc,
   input  logic        i_inst_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int OCC_W = CNT_W + 1;

   logic [11:0]      pc;
   logic [11:0]      pc_p1;
   logic             vld_p1;
   logic [15:0]      fifo_inst [FIFO_DEPTH];
   logic [11:0]      fifo_pc   [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [CNT_W-1:0] count;
   logic [OCC_W-1:0] occupancy;
   logic             inst_valid;
   logic             pop;
   logic             push;
   logic             issue;

   assign inst_valid = (count != '0);
   assign pop        = inst_valid & i_inst_ready & ~i_redirect;
   assign push       = vld_p1 & ~i_redirect;

   // Slots that will be occupied after this edge, counting the word still in
   // flight; issuing only while this is below depth keeps the FIFO from overflowing.
   assign occupancy = OCC_W'(count) + OCC_W'(vld_p1) - OCC_W'(pop);
   assign issue     = ~i_reset & ~i_halt & ~i_redirect &
                      (occupancy < OCC_W'(FIFO_DEPTH));

   assign o_imem_addr  = pc;
   assign o_imem_en    = issue;
   assign o_inst_valid = inst_valid;
   assign o_inst       = inst_valid ? fifo_inst[rd_ptr] : '0;
   assign o_inst_pc    = inst_valid ? fifo_pc[rd_ptr]   : '0;

   // Control state: PC, in-flight flag and FIFO pointers/occupancy
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         pc     <= RESET_PC;
         vld_p1 <= 1'b0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         vld_p1 <= issue;
         if (i_redirect) begin
            // Flush: buffered and in-flight words belong to the old path
            pc     <= i_redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (issue) pc <= pc + 12'd1;
            if (push)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
            if (push & ~pop)      count <= count + CNT_W'(1);
            else if (pop & ~push) count <= count - CNT_W'(1);
         end
      end
   end

   // Datapath: p0 -> p1 remembers the issued PC; p1 -> FIFO captures the returned word
   always_ff @(posedge i_clk) begin
      if (issue) pc_p1 <= pc;
      if (push) begin
         fifo_inst[wr_ptr] <= i_imem_data;
         fifo_pc[wr_ptr]   <= pc_p1;
      end
   end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios followed by random
// ready/halt/redirect/reset traffic. Delivered instructions are scored against
// the expected sequential program stream, restarted on redirect and reset.
module tb_instruction_fetch_unit;

   localparam logic [11:0] RESET_PC   = 12'hFFE;
   localparam int          FIFO_DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] imem_addr;
   logic        imem_en;
   logic [15:0] imem_data = 16'h0000;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic        halt;
   logic        inst_valid;
   logic [15:0] inst;
   logic [11:0] inst_pc;
   logic        inst_ready;

   logic [15:0] mem [4096];

   typedef struct {
      logic [11:0] pc;
      logic [15:0] data;
   } exp_t;

   exp_t        exp_q [$];
   logic [11:0] next_push;
   logic [11:0] exp_issue = RESET_PC;
   int          n_cmp  = 0;
   int          n_fail = 0;

   logic        hold_prev = 1'b0;
   logic [15:0] prev_inst;
   logic [11:0] prev_pc;

   instruction_fetch_unit #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .i_clk        (clk),
      .i_reset      (rst),
      .o_imem_addr  (imem_addr),
      .o_imem_en    (imem_en),
      .i_imem_data  (imem_data),
      .i_redirect   (redirect),
      .i_redirect_pc(redirect_pc),
      .i_halt       (halt),
      .o_inst_valid (inst_valid),
      .o_inst       (inst),
      .o_inst_pc    (inst_pc),
      .i_inst_ready (inst_ready)
   );

   always #5 clk = ~clk;

   // Instruction memory: registered read, output holds while not enabled
   always @(posedge clk) begin
      if (imem_en) imem_data <= mem[imem_addr];
   end

   function automatic void chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic push_seq(input int n);
      for (int i = 0; i < n; i++) begin
         exp_t e;
         e.pc   = next_push;
         e.data = mem[next_push];
         exp_q.push_back(e);
         next_push = next_push + 12'd1;
      end
   endtask

   task automatic start_stream(input logic [11:0] start_pc);
      exp_q.delete();
      next_push = start_pc;
      push_seq(32);
   endtask

   task automatic drive_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int lat);
      lat = 0;
      while (!inst_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Monitor: scoreboard on handshakes, issue-address sequence, hold stability
   always @(negedge clk) begin
      if (hold_prev) begin
         chk("hold_valid", int'(inst_valid), 1);
         chk("hold_inst", int'(inst), int'(prev_inst));
         chk("hold_pc", int'(inst_pc), int'(prev_pc));
      end
      hold_prev = inst_valid & ~inst_ready & ~redirect & ~rst;
      prev_inst = inst;
      prev_pc   = inst_pc;

      if (rst) begin
         chk("en_in_reset", int'(imem_en), 0);
         exp_issue = RESET_PC;
      end else if (redirect) begin
         chk("en_in_redirect", int'(imem_en), 0);
         exp_issue = redirect_pc;
      end else begin
         if (halt) chk("en_in_halt", int'(imem_en), 0);
         if (imem_en) begin
            chk("issue_addr", int'(imem_addr), int'(exp_issue));
            exp_issue = exp_issue + 12'd1;
         end
         if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_underflow", 1, 0);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk("sb_pc", int'(inst_pc), int'(e.pc));
               chk("sb_data", int'(inst), int'(e.data));
               if (exp_q.size() < 16) push_seq(16);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int cnt;
      int first;

      for (int k = 0; k < 4096; k++) mem[k] = 16'h1000 + 16'(k);
      rst = 1'b1; inst_ready = 1'b0; halt = 1'b0; redirect = 1'b0; redirect_pc = '0;
      start_stream(RESET_PC);

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", int'(inst_valid), 0);
      chk("rst_en", int'(imem_en), 0);
      chk("rst_inst", int'(inst), 0);
      chk("rst_inst_pc", int'(inst_pc), 0);

      // Release with ready high: wrap FFE,FFF,000,001 streamed without bubbles
      drive_edge();
      rst = 1'b0; inst_ready = 1'b1;
      start_stream(RESET_PC);
      @(negedge clk);
      chk("first_en", int'(imem_en), 1);
      chk("first_addr", int'(imem_addr), int'(RESET_PC));
      wait_valid(lat);
      chk("reset_latency", lat, 2);
      chk("first_pc", int'(inst_pc), int'(RESET_PC));
      repeat (6) begin
         @(negedge clk);
         chk("stream_valid", int'(inst_valid), 1);
      end

      // Redirect to 0 with decode stalled: exactly FIFO_DEPTH fetches, valid at R+3
      drive_edge();
      redirect = 1'b1; redirect_pc = 12'h000; inst_ready = 1'b0;
      start_stream(12'h000);
      @(negedge clk);
      drive_edge();
      redirect = 1'b0;
      cnt = 0; first = -1;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (imem_en) cnt++;
         if (inst_valid && first < 0) first = i;
      end
      chk("bp_fetch_count", cnt, FIFO_DEPTH);
      chk("bp_valid_at", first, 3);
      chk("bp_head_pc", int'(inst_pc), 0);
      chk("bp_head_data", int'(inst), int'(mem[0]));
      drive_edge();
      inst_ready = 1'b1;
      repeat (8) @(negedge clk);

      // Redirect mid-stream to 0x080: old words dropped, target valid at R+3
      drive_edge();
      redirect = 1'b1; redirect_pc = 12'h080;
      start_stream(12'h080);
      @(negedge clk);
      drive_edge();
      redirect = 1'b0;
      @(negedge clk);
      wait_valid(lat);
      chk("redirect_latency", lat + 1, 3);
      chk("redirect_pc", int'(inst_pc), 12'h080);
      repeat (6) @(negedge clk);

      // Halt 4 cycles: buffered plus in-flight word still delivered, no new fetches
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
         drive_edge();
         halt = 1'b1;
         @(negedge clk);
         if (inst_valid && inst_ready) cnt++;
      end
      chk("halt_drain_count", cnt, 2);
      drive_edge();
      halt = 1'b0;
      repeat (10) @(negedge clk);

      // Reset with a word buffered and one in flight
      drive_edge();
      rst = 1'b1; inst_ready = 1'b0;
      start_stream(RESET_PC);
      @(negedge clk);
      drive_edge();
      @(negedge clk);
      chk("midrst_valid", int'(inst_valid), 0);
      chk("midrst_en", int'(imem_en), 0);
      drive_edge();
      rst = 1'b0; inst_ready = 1'b1;
      @(negedge clk);
      chk("midrst_restart_addr", int'(imem_addr), int'(RESET_PC));
      wait_valid(lat);
      chk("midrst_latency", lat, 2);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         drive_edge();
         rst         = ($urandom_range(0, 199) == 0);
         redirect    = ($urandom_range(0, 29) == 0);
         redirect_pc = 12'($urandom);
         if ($urandom_range(0, 9) == 0) halt = ~halt;
         inst_ready  = ($urandom_range(0, 3) != 0);
         if (rst)           start_stream(RESET_PC);
         else if (redirect) start_stream(redirect_pc);
      end

      // Drain and confirm sustained one-per-cycle delivery
      drive_edge();
      rst = 1'b0; redirect = 1'b0; halt = 1'b0; inst_ready = 1'b1;
      repeat (6) @(negedge clk);
      repeat (10) begin
         @(negedge clk);
         chk("final_stream_valid", int'(inst_valid), 1);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
